// File: rtl/pdm_clk_sequencer_if.sv
// Control-side bundle of the PDM bit-clock sequencer.
// Valid/ready: cfg_div transfers on a cycle where cfg_valid & cfg_ready are both 1;
// the master holds cfg_valid and cfg_div stable until that cycle, and ready never depends on valid.
interface pdm_clk_sequencer_if #(
  parameter int DIV_W = 8
);
  logic             enable;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             mic_clk;
  logic             cap_r;
  logic             cap_l;
  logic             data_valid;
  logic             busy;
  logic [1:0]       state;

  modport master (
    output enable, cfg_div, cfg_valid,
    input  cfg_ready, mic_clk, cap_r, cap_l, data_valid, busy, state
  );

  modport slave (
    input  enable, cfg_div, cfg_valid,
    output cfg_ready, mic_clk, cap_r, cap_l, data_valid, busy, state
  );
endinterface

// File: rtl/pdm_clk_sequencer.sv
// PDM microphone bit-clock generator: programmable divider, start/stop gating,
// mic wake-up interval and per-edge capture strobes for the right/left channels.
module pdm_clk_sequencer #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 16,
  parameter int WAKE_EDGES  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  pdm_clk_sequencer_if.slave      bus
);

  localparam int WAKE_W = $clog2(WAKE_EDGES + 1);
  localparam logic [DIV_W-1:0] RESET_DIV =
    (DEFAULT_DIV < 2) ? DIV_W'(2) : DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAKE = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } state_e;

  state_e              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    cnt_q;
  logic [WAKE_W-1:0]   wake_cnt_q;
  logic                mic_clk_q;
  logic                cap_r_q;
  logic                cap_l_q;
  logic                data_valid_q;

  logic                tick;
  logic                rise_tick;
  logic                fall_tick;
  logic                cfg_ready;
  logic                cfg_fire;
  logic [DIV_W-1:0]    cfg_div_d;

  assign tick      = (state_q != IDLE) && (cnt_q == div_q - 1'b1);
  assign rise_tick = tick && !mic_clk_q;
  assign fall_tick = tick &&  mic_clk_q;

  // A new divisor may only land on a high->low boundary so no phase is ever shortened.
  assign cfg_ready = (state_q == IDLE) ||
                     (((state_q == WAKE) || (state_q == RUN)) && fall_tick);
  assign cfg_fire  = bus.cfg_valid && cfg_ready;
  assign cfg_div_d = (bus.cfg_div < DIV_W'(2)) ? DIV_W'(2) : bus.cfg_div;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      div_q        <= RESET_DIV;
      cnt_q        <= '0;
      wake_cnt_q   <= '0;
      mic_clk_q    <= 1'b0;
      cap_r_q      <= 1'b0;
      cap_l_q      <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      cap_r_q <= 1'b0;
      cap_l_q <= 1'b0;

      if (cfg_fire) begin
        div_q <= cfg_div_d;
      end

      if (state_q != IDLE) begin
        if (tick) begin
          cnt_q     <= '0;
          mic_clk_q <= ~mic_clk_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (bus.enable) begin
            state_q <= WAKE;
            cnt_q   <= '0;
          end
        end
        WAKE: begin
          if (rise_tick && (wake_cnt_q != WAKE_W'(WAKE_EDGES))) begin
            wake_cnt_q <= wake_cnt_q + 1'b1;
          end
          if (!bus.enable) begin
            state_q <= STOP;
          end else if (wake_cnt_q == WAKE_W'(WAKE_EDGES)) begin
            state_q      <= RUN;
            data_valid_q <= 1'b1;
          end
        end
        RUN: begin
          // Strobes are gated by the data_valid value they will appear alongside.
          cap_r_q <= rise_tick && bus.enable;
          cap_l_q <= fall_tick && bus.enable;
          if (!bus.enable) begin
            state_q      <= STOP;
            data_valid_q <= 1'b0;
          end
        end
        STOP: begin
          if (fall_tick) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wake_cnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cfg_ready  = cfg_ready;
  assign bus.mic_clk    = mic_clk_q;
  assign bus.cap_r      = cap_r_q;
  assign bus.cap_l      = cap_l_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.state      = state_q;

endmodule

// File: tb/tb_pdm_clk_sequencer.sv
// Directed bench for pdm_clk_sequencer: divisor clamp table plus hand-written
// sequences for wake-up, reconfiguration, stop, restart and asynchronous reset.
module tb_pdm_clk_sequencer;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STOP = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  pdm_clk_sequencer_if #(.DIV_W(8)) bus ();

  pdm_clk_sequencer #(
    .DIV_W      (8),
    .DEFAULT_DIV(16),
    .WAKE_EDGES (1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [7:0] cfg_div;
    int         exp_half;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Steps negedges until mic_clk equals lvl; n is the number of edges taken.
  task automatic wait_mic(input logic lvl, input int budget, output int n, output int caps);
    n = 0;
    caps = 0;
    do begin
      @(negedge clk);
      n++;
      caps += int'(bus.cap_r) + int'(bus.cap_l);
    end while (bus.mic_clk !== lvl && n < budget);
    if (bus.mic_clk !== lvl) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_mic timeout: mic_clk stuck at %b, expected %b", bus.mic_clk, lvl);
      n = -1;
    end
  endtask

  task automatic wake_check(input string name, input int start_rises);
    int   rises;
    int   caps;
    int   cyc;
    int   rise_cyc;
    logic prev;
    rises    = start_rises;
    caps     = 0;
    cyc      = 0;
    rise_cyc = -100;
    prev     = bus.mic_clk;
    while (bus.data_valid !== 1'b1 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (!prev && bus.mic_clk) begin
        rises++;
        if (rises == 1024) rise_cyc = cyc;
      end
      prev = bus.mic_clk;
      if (bus.data_valid !== 1'b1) caps += int'(bus.cap_r) + int'(bus.cap_l);
    end
    check({name, "_rises"}, rises, 1024);
    check({name, "_dv_delay"}, cyc - rise_cyc, 1);
    check({name, "_wake_caps"}, caps, 0);
  endtask

  initial begin
    int n;
    int caps;
    int waited;
    int rises;
    logic [3:0] got;
    logic [3:0] exp_v;

    vecs[0] = '{8'd0, 2};
    vecs[1] = '{8'd1, 2};
    vecs[2] = '{8'd2, 2};
    vecs[3] = '{8'd3, 3};
    vecs[4] = '{8'd9, 9};

    bus.enable    = 1'b0;
    bus.cfg_div   = '0;
    bus.cfg_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mic_clk", bus.mic_clk, 0);
    check("rst_cap_r", bus.cap_r, 0);
    check("rst_cap_l", bus.cap_l, 0);
    check("rst_data_valid", bus.data_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cfg_ready", bus.cfg_ready, 1);
    check("rst_state", bus.state, ST_IDLE);
    rst = 1'b1;

    // Scenario 1: default divisor; enable is taken on the first edge, rise div_q edges later
    @(negedge clk);
    bus.enable = 1'b1;
    wait_mic(1'b1, 100, n, caps);
    check("t1_first_rise", n, 17);
    wait_mic(1'b0, 100, n, caps);
    check("t1_high", n, 16);
    wait_mic(1'b1, 100, n, caps);
    check("t1_low", n, 16);
    wake_check("t1", 2);

    // Scenario 2: reconfigure to 5 mid-high phase in RUN
    wait_mic(1'b0, 100, n, caps);
    check("t2_cap_l_run", bus.cap_l, 1);
    wait_mic(1'b1, 100, n, caps);
    check("t2_cap_r_run", bus.cap_r, 1);
    repeat (5) @(negedge clk);
    check("t2_ready_mid_high", bus.cfg_ready, 0);
    bus.cfg_div   = 8'd5;
    bus.cfg_valid = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.cfg_ready !== 1'b1 && waited < 40);
    check("t2_ready_wait", waited, 10);
    check("t2_ready_mic_high", bus.mic_clk, 1);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    check("t2_fall_after_accept", bus.mic_clk, 0);
    check("t2_ready_pulse_end", bus.cfg_ready, 0);
    wait_mic(1'b1, 100, n, caps);
    check("t2_new_low", n, 5);
    wait_mic(1'b0, 100, n, caps);
    check("t2_new_high", n, 5);
    wait_mic(1'b1, 100, n, caps);
    check("t2_new_low2", n, 5);

    // Scenario 4: drop enable during the high phase
    @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    check("t4_dv_drop", bus.data_valid, 0);
    check("t4_busy_stop", bus.busy, 1);
    wait_mic(1'b0, 100, n, caps);
    check("t4_fall_edge", n, 3);
    check("t4_no_caps", caps, 0);
    check("t4_idle", bus.busy, 0);
    caps = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      caps += int'(bus.mic_clk) + int'(bus.busy);
    end
    check("t4_stays_low", caps, 0);

    // Divisor clamp table: cfg accept and enable rise together in IDLE
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("tab%0d_idle_ready", i), bus.cfg_ready, 1);
      bus.cfg_div   = vecs[i].cfg_div;
      bus.cfg_valid = 1'b1;
      bus.enable    = 1'b1;
      wait_mic(1'b1, 600, n, caps);
      bus.cfg_valid = 1'b0;
      check($sformatf("tab%0d_first_rise", i), n, vecs[i].exp_half + 1);
      wait_mic(1'b0, 600, n, caps);
      check($sformatf("tab%0d_high", i), n, vecs[i].exp_half);
      wait_mic(1'b1, 600, n, caps);
      check($sformatf("tab%0d_low", i), n, vecs[i].exp_half);
      bus.enable = 1'b0;
      wait_mic(1'b0, 600, n, caps);
      check($sformatf("tab%0d_stop_fall", i), n, vecs[i].exp_half);
      check($sformatf("tab%0d_stop_idle", i), bus.state, ST_IDLE);
    end

    // Scenario 3: divisor 1 clamps to 2; strobes alternate every 2 cycles in RUN
    @(negedge clk);
    bus.cfg_div   = 8'd1;
    bus.cfg_valid = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    bus.enable    = 1'b1;
    wake_check("t3", 0);
    waited = 0;
    while (bus.cap_r !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    for (int j = 0; j < 8; j++) begin
      case (j % 4)
        0: exp_q.push_back(4'b1100);
        1: exp_q.push_back(4'b1001);
        2: exp_q.push_back(4'b0010);
        default: exp_q.push_back(4'b0000);
      endcase
    end
    for (int j = 0; j < 8; j++) begin
      if (j != 0) @(negedge clk);
      got   = {bus.mic_clk, bus.cap_r, bus.cap_l, bus.cfg_ready};
      exp_v = exp_q.pop_front();
      check($sformatf("t3_pattern%0d", j), got, exp_v);
    end

    // Scenario 5: abort wake at rise 500, re-raise enable during STOP
    @(negedge clk);
    bus.enable = 1'b0;
    waited = 0;
    while (bus.busy !== 1'b0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("t5_idle_before", bus.busy, 0);
    bus.enable = 1'b1;
    rises = 0;
    waited = 0;
    while (rises < 500 && waited < 3000) begin
      wait_mic(1'b1, 10, n, caps);
      rises++;
      waited += 4;
      if (rises < 500) wait_mic(1'b0, 10, n, caps);
    end
    bus.enable = 1'b0;
    @(negedge clk);
    bus.enable = 1'b1;
    check("t5_in_stop", bus.state, ST_STOP);
    check("t5_dv_low", bus.data_valid, 0);
    wait_mic(1'b0, 10, n, caps);
    check("t5_stop_fall", n, 1);
    check("t5_reach_idle", bus.busy, 0);
    wake_check("t5", 0);

    // Scenario 6: asynchronous reset mid-RUN while mic_clk is high
    wait_mic(1'b1, 10, n, caps);
    @(posedge clk);
    #2;
    check("t6_pre_mic_high", bus.mic_clk, 1);
    rst = 1'b0;
    #1;
    check("t6_mic_clk", bus.mic_clk, 0);
    check("t6_cap_r", bus.cap_r, 0);
    check("t6_cap_l", bus.cap_l, 0);
    check("t6_data_valid", bus.data_valid, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_cfg_ready", bus.cfg_ready, 1);
    bus.enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.enable = 1'b1;
    wait_mic(1'b1, 100, n, caps);
    check("t6_first_rise", n, 17);
    wait_mic(1'b0, 100, n, caps);
    check("t6_high", n, 16);
    wait_mic(1'b1, 100, n, caps);
    check("t6_low", n, 16);
    check("t6_dv_still_low", bus.data_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
